snes_pad_reader: RTL and testbench
==================================

// Module: snes_pad_reader
// PURPOSE
//  Host-side reader for a physical SNES gamepad, the controller-port master that drives LATCH/CLK and samples DATA.
//  Polls the pad periodically, shifts in 16 button bits plus one presence bit, and presents a stable active-low
//  button word in the same format as joy1_buttons (bit0=B ... bit7=RIGHT, bit8-11=A,X,L,R, bit12-15=ID).
//  Sits in the top level on clk_sys; its buttons output feeds the console-side joypad shift register.
// PARAMETERS
//  HALF_CYCLES   128     clk cycles per pad_clk half period (min 4; ~6 us at 21.48 MHz)
//  LATCH_CYCLES  256     clk cycles pad_latch is held high (min 1)
//  POLL_CYCLES   357955  clk cycles between poll starts (~60 Hz); must exceed one full read
//  CNT_W         20      width of internal cycle counter; 2**CNT_W > POLL_CYCLES
// PORTS
//  clk        in   1   system clock (clk_sys)
//  reset      in   1   synchronous reset, active high
//  pad_latch  out  1   controller LATCH, active high
//  pad_clk    out  1   controller CLK, idles high, pad shifts on rising edge
//  pad_data   in   1   controller DATA, low = pressed; asynchronous, pulled up externally
//  buttons    out  16  last complete read, active low (0 = pressed)
//  connected  out  1   1 = pad drove 17th bit low on last read
//  valid      out  1   one-cycle pulse when buttons/connected update
// BEHAVIOUR
//  - Reset values: pad_latch=0, pad_clk=1, buttons=16'hFFFF, connected=0, valid=0; FSM -> IDLE, counters cleared.
//  - pad_data passes a 2-flop synchronizer before use; all samples taken from synchronizer output.
//  - Poll timer free-runs from reset release; wraps at POLL_CYCLES-1; wrap in IDLE starts a read.
//    First read begins POLL_CYCLES cycles after reset deasserts. Wrap while a read is active is ignored.
//  - FSM: IDLE -> LATCH -> SETTLE -> LOW -> HIGH -> ... -> DONE -> IDLE.
//    IDLE: pad_latch=0, pad_clk=1.
//    LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles; bit index cleared to 0.
//    SETTLE: pad_latch=0, pad_clk=1 for HALF_CYCLES; on last cycle sample bit 0.
//    LOW: pad_clk=0 for HALF_CYCLES.
//    HIGH: pad_clk=1 for HALF_CYCLES; on last cycle sample next bit (index+1).
//    After LOW/HIGH, goes LOW again while index<16, else DONE; total 17 samples, 16 pad_clk low pulses.
//  - Sample i (0..15) stored into shift register bit i as raw line level (low=pressed); sample 16 is presence.
//  - DONE (1 cycle): buttons <= captured 16 bits; connected <= ~sample16; valid=1 this cycle only; -> IDLE.
//  - buttons/connected change only in DONE; never show partial reads.
//  - Pad absent (line pulled high): buttons=16'hFFFF, connected=0; valid still pulses.
//  - Reset mid-read: read aborted, outputs forced to reset values same cycle edge; no valid pulse.
//  - Read duration = LATCH_CYCLES + 33*HALF_CYCLES + 1 cycles; pad_clk period = 2*HALF_CYCLES.
// TESTING
//  - Reset: assert reset mid-LATCH -> next cycle pad_latch=0, pad_clk=1, buttons=FFFF, connected=0, no valid.
//  - Timing (HALF=4, LATCH=6, POLL=400): latch high 6 cycles; 16 pad_clk low pulses of 4 cycles; valid
//    exactly 6+132+1 cycles after latch rise; next latch rise 400 cycles after previous.
//  - Pad model drives 16'b1111_1111_0101_1010 then 0 on bit 16 -> buttons=16'hFF5A, connected=1, valid once.
//  - Data tied high (no pad) -> buttons=16'hFFFF, connected=0, valid pulses every poll.
//  - Pad model changes pattern mid-read -> buttons stays old value until DONE, then reflects sampled bits only.
//  - Glitch on pad_data shorter than 2 cycles away from sample points -> buttons unaffected.

Source files
------------

// File: rtl/snes_pad_reader_if.sv
// snes_pad_reader_if
//   Bundles the controller-port lines and the decoded button word of the
//   SNES pad reader.
//   master : the reader (drives pad_latch/pad_clk and the result signals, samples pad_data)
//   slave  : the pad side plus the consumer of the result signals
//   Signals:
//     pad_latch  controller LATCH, active high
//     pad_clk    controller CLK, idles high, pad shifts on its rising edge
//     pad_data   controller DATA, low = pressed, pulled up externally
//     buttons    last complete read, active low
//     connected  1 = pad drove the 17th bit low on the last read
//     valid      one-cycle pulse when buttons/connected update
interface snes_pad_reader_if;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic [15:0] buttons;
  logic        connected;
  logic        valid;

  modport master (
    output pad_latch, pad_clk, buttons, connected, valid,
    input  pad_data
  );

  modport slave (
    input  pad_latch, pad_clk, buttons, connected, valid,
    output pad_data
  );
endinterface

// File: rtl/snes_pad_reader.sv
// snes_pad_reader
//   Host-side SNES gamepad reader. Polls the pad every POLL_CYCLES clocks,
//   pulses LATCH, clocks out 16 button bits plus one presence bit, and
//   presents a stable active-low button word (bit0=B ... bit7=RIGHT,
//   bit8-11=A,X,L,R, bit12-15=ID).
//   Ports:
//     clk    system clock (clk_sys)
//     reset  synchronous reset, active high
//     pad    snes_pad_reader_if.master: pad_latch, pad_clk, pad_data,
//            buttons, connected, valid
module snes_pad_reader #(
  parameter int unsigned HALF_CYCLES  = 128,
  parameter int unsigned LATCH_CYCLES = 256,
  parameter int unsigned POLL_CYCLES  = 357955,
  parameter int unsigned CNT_W        = 20
) (
  input logic                clk,
  input logic                reset,
  snes_pad_reader_if.master  pad
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   poll_cnt;
  logic [CNT_W-1:0]   phase_cnt;
  logic [4:0]         bit_idx;
  logic [16:0]        cap;
  logic               data_meta, data_sync;
  logic [15:0]        buttons_q;
  logic               connected_q;
  logic               valid_q;

  logic               poll_wrap;
  logic               phase_last;
  logic               sample_en;
  logic [4:0]         sample_idx;
  logic               latch_c;
  logic               pclk_c;

  assign poll_wrap = (poll_cnt == CNT_W'(POLL_CYCLES - 1));

  always_comb begin
    state_n    = state;
    latch_c    = 1'b0;
    pclk_c     = 1'b1;
    phase_last = 1'b0;
    sample_en  = 1'b0;
    sample_idx = bit_idx;
    case (state)
      S_IDLE: begin
        if (poll_wrap) state_n = S_LATCH;
      end
      S_LATCH: begin
        latch_c    = 1'b1;
        phase_last = (phase_cnt == CNT_W'(LATCH_CYCLES - 1));
        if (phase_last) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        phase_last = (phase_cnt == CNT_W'(HALF_CYCLES - 1));
        if (phase_last) begin
          sample_en  = 1'b1;
          sample_idx = 5'd0;
          state_n    = S_LOW;
        end
      end
      S_LOW: begin
        pclk_c     = 1'b0;
        phase_last = (phase_cnt == CNT_W'(HALF_CYCLES - 1));
        if (phase_last) state_n = S_HIGH;
      end
      S_HIGH: begin
        phase_last = (phase_cnt == CNT_W'(HALF_CYCLES - 1));
        if (phase_last) begin
          sample_en  = 1'b1;
          sample_idx = bit_idx + 5'd1;
          // bit 16 (presence) is the last sample
          state_n    = (bit_idx == 5'd15) ? S_DONE : S_LOW;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      poll_cnt    <= '0;
      phase_cnt   <= '0;
      bit_idx     <= '0;
      cap         <= '1;
      data_meta   <= 1'b1;
      data_sync   <= 1'b1;
      buttons_q   <= '1;
      connected_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state     <= state_n;
      data_meta <= pad.pad_data;
      data_sync <= data_meta;
      poll_cnt  <= poll_wrap ? '0 : poll_cnt + CNT_W'(1);

      if (state == S_IDLE || state_n != state)
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + CNT_W'(1);

      if (state == S_LATCH)
        bit_idx <= '0;
      else if (state == S_HIGH && phase_last)
        bit_idx <= bit_idx + 5'd1;

      if (sample_en)
        cap[sample_idx] <= data_sync;

      // Result registers and valid update together on the DONE edge, so
      // valid is high in the first cycle the new word is visible.
      valid_q <= (state == S_DONE);
      if (state == S_DONE) begin
        buttons_q   <= cap[15:0];
        connected_q <= ~cap[16];
      end
    end
  end

  assign pad.pad_latch = latch_c;
  assign pad.pad_clk   = pclk_c;
  assign pad.buttons   = buttons_q;
  assign pad.connected = connected_q;
  assign pad.valid     = valid_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader
//   Self-checking bench for snes_pad_reader with small timing parameters.
//   A behavioural pad drives pad_data; expected {connected, buttons} words
//   are queued before each read and checked when valid pulses.
module tb_snes_pad_reader;
  localparam int HALF  = 4;
  localparam int LATCH = 6;
  localparam int POLL  = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snes_pad_reader_if pad ();

  snes_pad_reader #(
    .HALF_CYCLES (HALF),
    .LATCH_CYCLES(LATCH),
    .POLL_CYCLES (POLL),
    .CNT_W       (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pad  (pad)
  );

  int total = 0;
  int bad   = 0;

  // Pad model: bit counter cleared while LATCH is high, advanced on each
  // rising pad_clk; bit k comes from pat_b once k >= swap_bit.
  logic [16:0] pat_a    = 17'h1FFFF;
  logic [16:0] pat_b    = 17'h1FFFF;
  int          swap_bit = 32;
  logic        present  = 1'b1;
  logic        glitch   = 1'b0;
  int          pcnt     = 0;
  logic        prev_clk = 1'b1;
  logic        model_bit;

  always_comb begin
    model_bit = 1'b1;
    if (pcnt <= 16)
      model_bit = (pcnt >= swap_bit) ? pat_b[pcnt] : pat_a[pcnt];
  end

  assign pad.pad_data = (present ? model_bit : 1'b1) ^ glitch;

  always @(negedge clk) begin
    if (pad.pad_latch)
      pcnt <= 0;
    else if (pad.pad_clk && !prev_clk && pcnt < 17)
      pcnt <= pcnt + 1;
    prev_clk <= pad.pad_clk;
  end

  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic score();
    logic [16:0] e;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("buttons", 32'(pad.buttons), 32'(e[15:0]));
      check("connected", 32'(pad.connected), 32'(e[16]));
    end
  endtask

  task automatic wait_latch();
    for (int i = 0; i < 1000 && !pad.pad_latch; i++) @(negedge clk);
    check("latch_seen", 32'(pad.pad_latch), 32'd1);
  endtask

  task automatic wait_valid_score(output int waited);
    waited = 0;
    @(negedge clk);
    while (!pad.valid && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("valid_seen", 32'(pad.valid), 32'd1);
    if (pad.valid) score();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, 32'(pad.pad_latch), 32'd0);
    check({tag, "_pclk"}, 32'(pad.pad_clk), 32'd1);
    check({tag, "_buttons"}, 32'(pad.buttons), 32'hFFFF);
    check({tag, "_connected"}, 32'(pad.connected), 32'd0);
    check({tag, "_valid"}, 32'(pad.valid), 32'd0);
  endtask

  initial begin
    int cyc, lat_hi, lows, low_len, bad_len, vcyc, w, nv;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Pad present, FF5A + presence low; measure full read timing
    pat_a = 17'h0_FF5A;
    pat_b = 17'h0_FF5A;
    exp_q.push_back({1'b1, 16'hFF5A});
    @(negedge clk);
    reset = 1'b0;
    wait_latch();
    cyc = 0; lat_hi = 0; lows = 0; low_len = 0; bad_len = 0; vcyc = -1;
    while (cyc < 600 && vcyc < 0) begin
      if (pad.pad_latch) lat_hi++;
      if (!pad.pad_clk) low_len++;
      else if (low_len != 0) begin
        lows++;
        if (low_len != HALF) bad_len++;
        low_len = 0;
      end
      if (pad.valid) begin
        vcyc = cyc;
        score();
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("latch_high_cycles", 32'(lat_hi), 32'(LATCH));
    check("pclk_low_pulses", 32'(lows), 32'd16);
    check("pclk_low_width_errs", 32'(bad_len), 32'd0);
    check("valid_latency", 32'(vcyc), 32'(LATCH + 33 * HALF + 1));

    exp_q.push_back({1'b1, 16'hFF5A});
    @(negedge clk);
    cyc++;
    check("valid_once", 32'(pad.valid), 32'd0);
    while (!pad.pad_latch && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("poll_period", 32'(cyc), 32'(POLL));
    wait_valid_score(w);

    // No pad: line pulled high; valid still pulses every poll
    present = 1'b0;
    exp_q.push_back({1'b0, 16'hFFFF});
    wait_valid_score(w);
    exp_q.push_back({1'b0, 16'hFFFF});
    wait_valid_score(w);
    check("valid_period", 32'(w + 1), 32'(POLL));

    // Pattern changes mid-read: low byte from old, rest from new
    present  = 1'b1;
    pat_a    = 17'h0_1234;
    pat_b    = 17'h0_ABCD;
    swap_bit = 8;
    exp_q.push_back({1'b1, 16'hAB34});
    wait_latch();
    for (int i = 0; i < 400 && pcnt < 10; i++) @(negedge clk);
    check("no_partial_buttons", 32'(pad.buttons), 32'hFFFF);
    check("no_partial_connected", 32'(pad.connected), 32'd0);
    wait_valid_score(w);
    swap_bit = 32;

    // Single-cycle glitches during pad_clk low phases
    pat_a = 17'h0_C3A5;
    pat_b = 17'h0_C3A5;
    exp_q.push_back({1'b1, 16'hC3A5});
    wait_latch();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 200 && !pad.pad_clk; i++) @(negedge clk);
      for (int i = 0; i < 200 && pad.pad_clk; i++) @(negedge clk);
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
    end
    wait_valid_score(w);

    // Reset in the middle of LATCH aborts the read
    wait_latch();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pad.valid) nv++;
    end
    check("no_valid_after_abort", 32'(nv), 32'd0);
    exp_q.push_back({1'b1, 16'hC3A5});
    wait_valid_score(w);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
